// File: rtl/a2_instruction_fetch_if.sv
// Fetch-stage bus: control inputs, program-load port and IF/ID outputs.
// The stage itself connects through the slave modport.
interface a2_instruction_fetch_if #(
   parameter int IW = 8,
   parameter int AW = 4
);
   logic          start;
   logic          stall;
   logic          PCSrc;
   logic [AW-1:0] jump_target;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [IW-1:0] imem_wdata;
   logic [IW-1:0] instr;
   logic [2:0]    opcode;
   logic [AW-1:0] id_pc;
   logic          id_valid;
   logic [AW-1:0] pc;
   logic          running;

   modport master (
      output start, stall, PCSrc, jump_target, imem_we, imem_waddr, imem_wdata,
      input  instr, opcode, id_pc, id_valid, pc, running
   );

   modport slave (
      input  start, stall, PCSrc, jump_target, imem_we, imem_waddr, imem_wdata,
      output instr, opcode, id_pc, id_valid, pc, running
   );
endinterface

// File: rtl/a2_instruction_fetch.sv
// Instruction fetch stage: PC, writable instruction memory and the IF/ID register,
// with stall, one-slot jump flush and a start-up IDLE/RUN handshake.
module a2_instruction_fetch #(
   parameter int IW = 8,
   parameter int AW = 4
) (
   input logic                  clk,
   input logic                  reset_n,
   a2_instruction_fetch_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [IW-1:0] instr_q, instr_d;
   logic [AW-1:0] id_pc_q, id_pc_d;
   logic          id_valid_q, id_valid_d;

   // Program memory is deliberately not reset so contents survive a mid-run reset.
   logic [IW-1:0] mem_q [2**AW];
   logic [IW-1:0] fetch_word;

   assign fetch_word = mem_q[pc_q];

   always_ff @(posedge clk) begin
      if (bus.imem_we) begin
         mem_q[bus.imem_waddr] <= bus.imem_wdata;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      id_pc_d    = id_pc_q;
      id_valid_d = id_valid_q;
      case (state_q)
         IDLE: begin
            pc_d       = '0;
            instr_d    = '0;
            id_pc_d    = '0;
            id_valid_d = 1'b0;
            if (bus.start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // A stalled decode re-presents its jump next cycle, so PCSrc waits too.
            if (bus.stall) begin
               pc_d = pc_q;
            end else if (bus.PCSrc && id_valid_q) begin
               pc_d       = bus.jump_target;
               instr_d    = '0;
               id_pc_d    = '0;
               id_valid_d = 1'b0;
            end else begin
               instr_d    = fetch_word;
               id_pc_d    = pc_q;
               id_valid_d = 1'b1;
               pc_d       = pc_q + AW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         instr_q    <= '0;
         id_pc_q    <= '0;
         id_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         id_pc_q    <= id_pc_d;
         id_valid_q <= id_valid_d;
      end
   end

   assign bus.instr    = instr_q;
   assign bus.opcode   = {1'b0, instr_q[IW-1:IW-2]};
   assign bus.id_pc    = id_pc_q;
   assign bus.id_valid = id_valid_q;
   assign bus.pc       = pc_q;
   assign bus.running  = (state_q == RUN);
endmodule

// File: doc/a2_instruction_fetch.md
# a2_instruction_fetch

Instruction fetch stage and IF/ID pipeline register of the pipelined datapath. Holds the PC, a small writable instruction memory, and the IF/ID register whose opcode field drives the control unit directly downstream. Applies jump redirects (PCSrc from the control unit) with a one-slot flush, and supports stall and a start-up handshake.

## Interface
- IW, 8, instruction width; op field is instr[IW-1:IW-2], jump target field is instr[AW-1:0]
- AW, 4, PC / instruction-memory address width; memory depth 2^AW words
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins fetching from PC 0
- stall  in  1  hold PC and IF/ID register this cycle
- PCSrc  in  1  jump taken, from the control unit (decode of current IF/ID contents)
- jump_target  in  AW  jump destination, valid with PCSrc
- imem_we  in  1  instruction-memory write enable (program load)
- imem_waddr  in  AW  write address
- imem_wdata  in  IW  write data
- instr  out  IW  IF/ID instruction
- opcode  out  3  {1'b0, instr[IW-1:IW-2]}, to control unit (00 li, 01 add, 11 j)
- id_pc  out  AW  address the IF/ID instruction was fetched from
- id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- pc  out  AW  current fetch address
- running  out  1  high in RUN state

## Operation
- FSM states: IDLE, RUN. Reset enters IDLE. IDLE -> RUN on start=1. RUN is absorbing; only reset_n returns to IDLE. start in RUN is ignored.
- IDLE: pc held at 0, IF/ID held at bubble (instr=0, id_valid=0, id_pc=0).
- RUN, priority per cycle (highest first):
  - stall=1: pc, instr, id_pc, id_valid all hold; PCSrc ignored this cycle (decode is held, so the jump is re-presented next cycle).
  - PCSrc=1 and id_valid=1: pc <= jump_target; IF/ID flushed to bubble (instr=0, id_valid=0, id_pc=0).
  - otherwise: instr <= imem[pc], id_pc <= pc, id_valid <= 1, pc <= pc+1 mod 2^AW.
- PCSrc with id_valid=0 is ignored (normal sequential fetch).
- PC wraps from 2^AW-1 to 0 with no flag.
- Instruction memory: 2^AW x IW, not reset (contents undefined until written). Write is synchronous on clk when imem_we=1, in any state. Same-cycle read/write of one address: fetch returns the old word (read-before-write).
- opcode is combinational from instr; bit 2 always 0.

## Timing
- Reset (reset_n=0, asynchronous): pc=0, instr=0, opcode=0, id_pc=0, id_valid=0, running=0, state IDLE. Reset mid-operation aborts immediately; the memory keeps its contents.
- start sampled at edge N: running=1 after edge N; first fetch (address 0) loaded into IF/ID at edge N+1, so id_valid rises after N+1.
- Sequential throughput: one instruction per cycle; fetch-to-IF/ID latency 1 cycle.
- Jump penalty: j in IF/ID at cycle k (PCSrc=1) -> bubble in IF/ID at k+1, instruction at jump_target in IF/ID at k+2.
- start and stall same cycle in IDLE: transition to RUN occurs; stall has no effect in IDLE.

## Test plan
- Reset/idle: load imem[0..3]={0x05,0x41,0x42,0x43}; hold reset_n=0 then release, no start for 5 cycles -> pc=0, id_valid=0, instr=0, running=0 throughout.
- Sequential fetch: pulse start -> IF/ID shows 0x05,0x41,0x42,0x43 on consecutive cycles with id_pc 0,1,2,3, opcode 0,1,1,1, id_valid=1.
- Jump: imem[2]=0xC9 (j), bench drives PCSrc=1, jump_target=9 while opcode=3 -> next cycle id_valid=0, instr=0; following cycle id_pc=9, instr=imem[9]; imem[3] never appears.
- Stall: assert stall 3 cycles while id_pc=1 -> pc, instr, id_pc frozen 3 cycles; resumes with id_pc=2; PCSrc pulse during stall has no effect.
- Wrap: run from pc=14 with no jumps -> id_pc sequence 14,15,0,1.
- Reset mid-run: drop reset_n asynchronously between edges at id_pc=5 -> all outputs zero immediately, running=0; after release and start, fetch restarts at 0 with memory contents intact.
